// File: rtl/imem_responder.sv
// Instruction-fetch RAM responder: serves 32-bit fetch words as two 16-bit SRAM
// beats and arbitrates a lower-priority 16-bit data port onto the same SRAM.
module imem_responder #(
  parameter int WAIT_CYC = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_read,
  input  logic        ram_addr_ovr,
  input  logic [15:0] ram_addr,
  output logic        ram_cack,
  output logic        ram_busy,
  output logic [31:0] ram_data,
  output logic        ram_data_ready,
  input  logic        dmem_req,
  input  logic        dmem_we,
  input  logic [16:0] dmem_addr,
  input  logic [15:0] dmem_wdata,
  output logic [15:0] dmem_rdata,
  output logic        dmem_ack,
  output logic [16:0] sram_addr,
  input  logic [15:0] sram_dq_i,
  output logic [15:0] sram_dq_o,
  output logic        sram_dq_oe,
  output logic        sram_oe,
  output logic        sram_we
);

  localparam int CW = $clog2(WAIT_CYC + 2);

  typedef enum logic [1:0] {IDLE, F_LO, F_HI, D_ACC} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          beat_done;
  logic          fetch_go;
  logic          dmem_go;
  logic [15:0]   fetch_addr;
  logic          d_we;
  logic [16:0]   d_addr;
  logic [15:0]   d_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Fetch has priority over the data port; a held dmem_req is picked up on a later idle cycle.
  always_comb begin
    state_next = state;
    beat_done  = (cnt == CW'(WAIT_CYC));
    fetch_go   = 1'b0;
    dmem_go    = 1'b0;
    sram_addr  = '0;
    sram_dq_o  = '0;
    sram_dq_oe = 1'b0;
    sram_oe    = 1'b0;
    sram_we    = 1'b0;
    case (state)
      IDLE: begin
        if (ram_read && ram_addr_ovr) begin
          fetch_go   = 1'b1;
          state_next = F_LO;
        end else if (dmem_req) begin
          dmem_go    = 1'b1;
          state_next = D_ACC;
        end
      end
      F_LO: begin
        sram_addr = {fetch_addr, 1'b0};
        sram_oe   = 1'b1;
        if (beat_done) state_next = F_HI;
      end
      F_HI: begin
        sram_addr = {fetch_addr, 1'b1};
        sram_oe   = 1'b1;
        if (beat_done) state_next = IDLE;
      end
      D_ACC: begin
        sram_addr = d_addr;
        if (d_we) begin
          sram_we    = 1'b1;
          sram_dq_oe = 1'b1;
          sram_dq_o  = d_wdata;
        end else begin
          sram_oe = 1'b1;
        end
        if (beat_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt            <= '0;
      fetch_addr     <= '0;
      d_we           <= 1'b0;
      d_addr         <= '0;
      d_wdata        <= '0;
      ram_cack       <= 1'b0;
      ram_busy       <= 1'b0;
      ram_data       <= '0;
      ram_data_ready <= 1'b0;
      dmem_rdata     <= '0;
      dmem_ack       <= 1'b0;
    end else begin
      ram_cack       <= fetch_go;
      ram_data_ready <= 1'b0;
      dmem_ack       <= 1'b0;
      if (state == IDLE || beat_done) cnt <= '0;
      else                            cnt <= cnt + CW'(1);
      if (fetch_go) begin
        fetch_addr <= ram_addr;
        ram_busy   <= 1'b1;
      end
      if (dmem_go) begin
        d_we     <= dmem_we;
        d_addr   <= dmem_addr;
        d_wdata  <= dmem_wdata;
        ram_busy <= 1'b1;
      end
      // Each beat samples the SRAM on the last cycle of its strobe window.
      case (state)
        F_LO: if (beat_done) ram_data[15:0] <= sram_dq_i;
        F_HI: begin
          if (beat_done) begin
            ram_data[31:16] <= sram_dq_i;
            ram_data_ready  <= 1'b1;
            ram_busy        <= 1'b0;
          end
        end
        D_ACC: begin
          if (beat_done) begin
            if (!d_we) dmem_rdata <= sram_dq_i;
            dmem_ack <= 1'b1;
            ram_busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: vector table, hand-written corner
// sequences and a randomized run against a word/halfword memory model.
module tb_imem_responder;

  localparam int W = 1;

  logic        clk;
  logic        rst;
  logic        ram_read;
  logic        ram_addr_ovr;
  logic [15:0] ram_addr;
  logic        ram_cack;
  logic        ram_busy;
  logic [31:0] ram_data;
  logic        ram_data_ready;
  logic        dmem_req;
  logic        dmem_we;
  logic [16:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic [15:0] dmem_rdata;
  logic        dmem_ack;
  logic [16:0] sram_addr;
  logic [15:0] sram_dq_i;
  logic [15:0] sram_dq_o;
  logic        sram_dq_oe;
  logic        sram_oe;
  logic        sram_we;

  imem_responder #(.WAIT_CYC(W)) dut (
    .clk(clk), .rst(rst),
    .ram_read(ram_read), .ram_addr_ovr(ram_addr_ovr), .ram_addr(ram_addr),
    .ram_cack(ram_cack), .ram_busy(ram_busy), .ram_data(ram_data),
    .ram_data_ready(ram_data_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .sram_addr(sram_addr), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o),
    .sram_dq_oe(sram_dq_oe), .sram_oe(sram_oe), .sram_we(sram_we)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [15:0] sramMem [0:131071];
  logic [15:0] refMem  [0:131071];
  logic [16:0] addrLog [$];
  int          weCount;
  int          overlapCount;
  int          nCompared;
  int          nMismatched;
  logic [31:0] lastFetch;

  assign sram_dq_i = sram_oe ? sramMem[sram_addr] : 16'hDEAD;

  typedef struct {
    bit          isFetch;
    bit          we;
    logic [16:0] addr;
    logic [15:0] wdata;
    logic [31:0] expData;
    int          expWe;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [15:0] initPattern(input logic [16:0] a);
    case (a)
      17'h00010: return 16'h1234;
      17'h00011: return 16'hABCD;
      17'h00004: return 16'h1111;
      17'h1FFFE: return 16'hC0DE;
      default:   return a[15:0] ^ {a[7:0], a[16:9]} ^ 16'h5A5A;
    endcase
  endfunction

  function automatic logic [31:0] refWord(input logic [15:0] a);
    int lo;
    lo = 2 * int'(a);
    return {refMem[lo + 1], refMem[lo]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // The SRAM model and strobe monitors live here so a single process owns them.
  task automatic tick();
    @(negedge clk);
    if (sram_we && sram_dq_oe) sramMem[sram_addr] = sram_dq_o;
    if (sram_we) weCount++;
    if (sram_we && sram_oe) overlapCount++;
    if (sram_oe) addrLog.push_back(sram_addr);
    @(posedge clk);
    #1;
  endtask

  task automatic doFetch(input logic [15:0] a, input bit scramble, output logic [31:0] data);
    int   cackT, readyT, nCack;
    logic busyAtCack, busyAtReady;
    cackT = -1; readyT = -1; nCack = 0; data = '0;
    busyAtCack = 1'b0; busyAtReady = 1'b1;
    ram_read = 1'b1; ram_addr_ovr = 1'b1; ram_addr = a;
    for (int t = 1; t <= 40 && readyT < 0; t++) begin
      tick();
      if (ram_cack) begin
        nCack++;
        if (cackT < 0) begin
          cackT = t;
          busyAtCack = ram_busy;
        end
      end
      if (ram_data_ready) begin
        readyT = t;
        data = ram_data;
        busyAtReady = ram_busy;
        ram_read = 1'b0; ram_addr_ovr = 1'b0;
      end else if (cackT > 0) begin
        if (scramble) begin
          ram_read = 1'($urandom); ram_addr_ovr = 1'($urandom); ram_addr = 16'($urandom);
        end else begin
          ram_read = 1'b0; ram_addr_ovr = 1'b0;
        end
      end
    end
    ram_read = 1'b0; ram_addr_ovr = 1'b0;
    checkOutput("fetch_cack_tick", 32'(cackT), 32'd1);
    checkOutput("fetch_latency", 32'(readyT - cackT), 32'(2 * W + 2));
    checkOutput("fetch_cack_count", 32'(nCack), 32'd1);
    checkOutput("fetch_busy_flags", {busyAtCack, busyAtReady}, 32'b10);
  endtask

  task automatic doDmem(input bit we, input logic [16:0] a, input logic [15:0] wd,
                        output logic [15:0] rd, output int weCyc, output int lat);
    int ackT;
    ackT = -1; rd = '0;
    weCount = 0;
    dmem_req = 1'b1; dmem_we = we; dmem_addr = a; dmem_wdata = wd;
    for (int t = 1; t <= 40 && ackT < 0; t++) begin
      tick();
      if (dmem_ack) begin
        ackT = t;
        rd = dmem_rdata;
        dmem_req = 1'b0;
      end else begin
        dmem_we = 1'($urandom); dmem_addr = 17'($urandom); dmem_wdata = 16'($urandom);
      end
    end
    dmem_req = 1'b0; dmem_we = 1'b0;
    weCyc = weCount;
    lat = ackT;
    if (we) refMem[a] = wd;
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    logic [31:0] fd;
    logic [15:0] rd;
    int          weCyc, lat;
    if (v.isFetch) begin
      doFetch(v.addr[15:0], 1'b0, fd);
      checkOutput($sformatf("vec%0d_fetch_data", idx), fd, v.expData);
      lastFetch = v.expData;
    end else begin
      doDmem(v.we, v.addr, v.wdata, rd, weCyc, lat);
      checkOutput($sformatf("vec%0d_ack_latency", idx), 32'(lat), 32'(W + 2));
      checkOutput($sformatf("vec%0d_we_cycles", idx), 32'(weCyc), 32'(v.expWe));
      if (!v.we) checkOutput($sformatf("vec%0d_read_data", idx), {16'h0, rd}, v.expData);
      checkOutput($sformatf("vec%0d_ram_data_hold", idx), ram_data, lastFetch);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] fd, expF;
    logic [15:0] rd;
    int          weCyc, lat, nC, rT, aT, cT, pulses, op;
    logic [15:0] fa;
    logic [16:0] da;
    logic [15:0] wd;

    nCompared = 0; nMismatched = 0; weCount = 0; overlapCount = 0; lastFetch = '0;
    for (int i = 0; i < 131072; i++) begin
      sramMem[i] = initPattern(17'(i));
      refMem[i]  = initPattern(17'(i));
    end

    vecs[0] = '{1'b1, 1'b0, 17'h00008, 16'h0000, 32'hABCD1234, 0};
    vecs[1] = '{1'b0, 1'b1, 17'h00005, 16'hBEEF, 32'h00000000, 2};
    vecs[2] = '{1'b0, 1'b0, 17'h00005, 16'h0000, 32'h0000BEEF, 0};
    vecs[3] = '{1'b1, 1'b0, 17'h00002, 16'h0000, 32'hBEEF1111, 0};
    vecs[4] = '{1'b0, 1'b0, 17'h00010, 16'h0000, 32'h00001234, 0};
    vecs[5] = '{1'b0, 1'b1, 17'h1FFFF, 16'h7E57, 32'h00000000, 2};
    vecs[6] = '{1'b1, 1'b0, 17'h0FFFF, 16'h0000, 32'h7E57C0DE, 0};
    vecs[7] = '{1'b0, 1'b0, 17'h1FFFE, 16'h0000, 32'h0000C0DE, 0};

    rst = 1'b1;
    ram_read = 1'b0; ram_addr_ovr = 1'b0; ram_addr = '0;
    dmem_req = 1'b0; dmem_we = 1'b0; dmem_addr = '0; dmem_wdata = '0;
    tick();
    tick();
    checkOutput("rst_ctrl_outs", {ram_cack, ram_busy, ram_data_ready, dmem_ack, sram_oe, sram_we, sram_dq_oe}, 32'h0);
    checkOutput("rst_ram_data", ram_data, 32'h0);
    checkOutput("rst_sram_bus", {sram_addr, sram_dq_o}, 32'h0);
    checkOutput("rst_dmem_rdata", {16'h0, dmem_rdata}, 32'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) applyStimulus(i, vecs[i]);

    // Top word address must map onto the last two halfwords without wrapping.
    addrLog.delete();
    doFetch(16'hFFFF, 1'b0, fd);
    checkOutput("edge_addr_count", 32'(addrLog.size()), 32'd4);
    if (addrLog.size() == 4) begin
      checkOutput("edge_addr_seq", {addrLog[0][15:0], addrLog[3][15:0]}, 32'hFFFEFFFF);
      checkOutput("edge_addr_msb", {addrLog[0][16], addrLog[1][16], addrLog[2][16], addrLog[3][16]}, 32'hF);
      checkOutput("edge_addr_mid", {addrLog[1][15:0], addrLog[2][15:0]}, 32'hFFFEFFFF);
    end
    lastFetch = fd;

    // Simultaneous fetch and data read: fetch first, then the held data request.
    ram_read = 1'b1; ram_addr_ovr = 1'b1; ram_addr = 16'h0001;
    dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 17'h00100;
    nC = 0; rT = -1; aT = -1; fd = '0; rd = '0;
    for (int t = 1; t <= 40 && aT < 0; t++) begin
      tick();
      if (ram_cack) begin
        nC++;
        ram_read = 1'b0; ram_addr_ovr = 1'b0;
      end
      if (ram_data_ready) begin
        rT = t;
        fd = ram_data;
      end
      if (dmem_ack) begin
        aT = t;
        rd = dmem_rdata;
        dmem_req = 1'b0;
      end
    end
    dmem_req = 1'b0;
    checkOutput("simul_cack_count", 32'(nC), 32'd1);
    checkOutput("simul_fetch_tick", 32'(rT), 32'(2 * W + 3));
    checkOutput("simul_ack_after_fetch", 32'(aT - rT), 32'(W + 2));
    checkOutput("simul_fetch_data", fd, refWord(16'h0001));
    checkOutput("simul_dmem_data", {16'h0, rd}, {16'h0, refMem[17'h00100]});
    lastFetch = fd;

    // Fetch request raised while a data transaction owns the SRAM.
    dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 17'h00020;
    tick();
    checkOutput("busy_during_dmem", {31'h0, ram_busy}, 32'h1);
    ram_read = 1'b1; ram_addr_ovr = 1'b1; ram_addr = 16'h0004;
    aT = -1; cT = -1; rT = -1; fd = '0; rd = '0;
    for (int t = 1; t <= 40 && rT < 0; t++) begin
      tick();
      if (dmem_ack) begin
        aT = t;
        rd = dmem_rdata;
        dmem_req = 1'b0;
      end
      if (ram_cack && cT < 0) begin
        cT = t;
        ram_read = 1'b0; ram_addr_ovr = 1'b0;
      end
      if (ram_data_ready) begin
        rT = t;
        fd = ram_data;
      end
    end
    ram_read = 1'b0; ram_addr_ovr = 1'b0; dmem_req = 1'b0;
    checkOutput("retry_ack_tick", 32'(aT), 32'(W + 1));
    checkOutput("retry_cack_after_idle", 32'(cT - aT), 32'd1);
    checkOutput("retry_fetch_latency", 32'(rT - cT), 32'(2 * W + 2));
    checkOutput("retry_fetch_data", fd, refWord(16'h0004));
    checkOutput("retry_dmem_data", {16'h0, rd}, {16'h0, refMem[17'h00020]});
    lastFetch = fd;

    // Reset landing in the high beat must abort the fetch with no completion pulse.
    ram_read = 1'b1; ram_addr_ovr = 1'b1; ram_addr = 16'h0006;
    tick();
    checkOutput("rstmid_cack", {31'h0, ram_cack}, 32'h1);
    ram_read = 1'b0; ram_addr_ovr = 1'b0;
    tick();
    tick();
    checkOutput("rstmid_in_hi_beat", {14'h0, sram_oe, sram_addr}, {14'h0, 1'b1, 17'h0000D});
    #1 rst = 1'b1;
    #1;
    checkOutput("rstmid_ctrl_outs", {ram_cack, ram_busy, ram_data_ready, dmem_ack, sram_oe, sram_we, sram_dq_oe}, 32'h0);
    checkOutput("rstmid_ram_data", ram_data, 32'h0);
    checkOutput("rstmid_sram_addr", {15'h0, sram_addr}, 32'h0);
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int t = 0; t < 8; t++) begin
      tick();
      pulses += int'(ram_data_ready) + int'(ram_cack) + int'(dmem_ack);
    end
    checkOutput("rstmid_no_pulses", 32'(pulses), 32'd0);
    lastFetch = '0;
    doFetch(16'h0006, 1'b0, fd);
    checkOutput("rstmid_next_fetch", fd, refWord(16'h0006));
    lastFetch = fd;

    // Randomized mix against the memory model.
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 2));
      if (op == 0) begin
        fa = 16'($urandom_range(0, 31));
        expF = refWord(fa);
        doFetch(fa, 1'b1, fd);
        checkOutput($sformatf("rand%0d_fetch_%h", i, fa), fd, expF);
        lastFetch = expF;
      end else begin
        da = 17'($urandom_range(0, 63));
        wd = 16'($urandom);
        expF = {16'h0, refMem[da]};
        doDmem(op == 2, da, wd, rd, weCyc, lat);
        checkOutput($sformatf("rand%0d_ack_latency", i), 32'(lat), 32'(W + 2));
        checkOutput($sformatf("rand%0d_we_cycles", i), 32'(weCyc), (op == 2) ? 32'(W + 1) : 32'd0);
        if (op == 1) checkOutput($sformatf("rand%0d_read_%h", i, da), {16'h0, rd}, expF);
        checkOutput($sformatf("rand%0d_ram_data_hold", i), ram_data, lastFetch);
      end
    end

    checkOutput("oe_we_exclusive", 32'(overlapCount), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
